operand_hazard_ctrl: RTL and testbench
======================================

Name: operand_hazard_ctrl

Overview:
- ID-stage operand controller. It sits between the register file read ports and the ID operand generator, and supplies the final reg_data_1/reg_data_2 values.
- Resolves RAW hazards by forwarding from EX/MEM/WB and interlocks on load-use.
- Holds resolved operands stable while the pipeline is stalled from downstream.
- Counts stall cycles and flags runaway interlocks for debug.

Parameters:
- MAX_STALL, 64, consecutive interlock cycles after which stall_timeout sets; range 1..255.
- CNT_WIDTH, 32, width of the stall_cycles performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a live instruction.
- id_read_en_1 / id_read_en_2  in  1  operand 1/2 uses a register.
- id_read_addr_1 / id_read_addr_2  in  5  source register numbers.
- rf_data_1 / rf_data_2  in  32  register file read data.
- ex_write_en  in  1  EX instruction writes a register.
- ex_write_addr  in  5  EX destination register.
- ex_result  in  32  EX ALU result.
- ex_is_load  in  1  EX instruction is a load.
- mem_write_en  in  1  MEM instruction writes a register.
- mem_write_addr  in  5  MEM destination register.
- mem_result  in  32  MEM result; load data when the load is ready.
- mem_is_load  in  1  MEM instruction is a load.
- mem_load_ready  in  1  load data valid on mem_result this cycle.
- wb_write_en  in  1  WB instruction writes a register.
- wb_write_addr  in  5  WB destination register.
- wb_result  in  32  WB write data.
- stall_in  in  1  downstream stall; the ID instruction does not advance.
- flush  in  1  kill the ID instruction.
- reg_data_1 / reg_data_2  out  32  resolved operands to the operand generator.
- stall_req  out  1  ID interlock request to the pipeline controller.
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with stall_req=1.
- stall_timeout  out  1  sticky flag: interlock lasted MAX_STALL cycles.

Behaviour:
- Forwarding, per operand n (combinational):
  - addr=0 or read_en=0 -> 0.
  - Otherwise first match wins, in this priority: EX hit (ex_write_en && ex_write_addr==addr) -> ex_result; then MEM hit -> mem_result; then WB hit -> wb_result; else rf_data_n.
- Hazard, per operand (combinational):
  - EX hit with ex_is_load=1 -> hazard.
  - MEM hit (and no EX hit) with mem_is_load=1 and mem_load_ready=0 -> hazard.
  - Addr 0 never hazards.
- stall_req = id_valid && !flush && (hazard_1 || hazard_2) && state!=HOLD. stall_req is 0 while rst=1.
- FSM states:
  - IDLE -> INTERLOCK when stall_req=1.
  - IDLE -> HOLD when id_valid && !hazard && stall_in && !flush. On this transition, latch both forwarded operands.
  - INTERLOCK -> IDLE when stall_req=0. If stall_in=1 in that same cycle, go to HOLD instead and latch.
  - HOLD -> IDLE when stall_in=0 or flush=1.
  - In HOLD, reg_data_n = latched values, ignoring all forwarding sources, including new EX/MEM/WB writes.
- flush: forces IDLE next cycle from any state; clears the interlock run counter; stall_req=0 in the flush cycle.
- Run counter (8-bit):
  - Increments each cycle stall_req=1; clears when stall_req=0.
  - When it reaches MAX_STALL, stall_timeout sets and stays set until rst.
- stall_cycles: increments each cycle stall_req=1; saturates at all-ones; does not wrap.
- Reset:
  - state=IDLE; latches=0; run counter=0; stall_cycles=0; stall_timeout=0.
  - rst asserted mid-INTERLOCK or mid-HOLD aborts immediately; next cycle is IDLE.
- Latency: forwarding and stall_req are zero-cycle (same cycle as inputs). Latching is 1 cycle.
- Simultaneous events:
  - flush beats stall_in and hazard.
  - EX hit beats MEM hit, even when the MEM data is ready.
  - Both operands hitting different loads -> stall until both clear.

Test Plan:
- Forward priority: rs=5, EX/MEM/WB all write r5 with 0x11/0x22/0x33, no loads -> reg_data_1=0x11, stall_req=0. Then drop EX -> 0x22; then drop MEM -> 0x33.
- Load-use: EX load to r7, ID reads r7 -> stall_req=1 for 1 cycle. Next cycle the load is in MEM with mem_load_ready=1 and mem_result=0xDEADBEEF -> stall_req=0, reg_data=0xDEADBEEF, stall_cycles=1.
- Slow memory: MEM load to r3 with mem_load_ready=0 for 4 cycles -> stall_req=1 for 4 cycles, then 0 with forwarded data. With MAX_STALL=3, stall_timeout=1 and it stays 1 after the stall ends.
- Hold: rf_data_1=0xA, stall_in=1 for 3 cycles, with WB writing r1=0xB on the 2nd cycle -> reg_data_1 stays 0xA throughout. After stall_in=0, IDLE and reg_data_1=0xB via regfile/forward.
- Register zero: read r0 while EX load targets r0 with ex_result=0x55 -> reg_data=0, stall_req=0.
- Flush and reset mid-operation: flush during INTERLOCK -> stall_req=0 that cycle, IDLE next cycle. rst during HOLD -> latches and counters read 0, stall_timeout=0.

Source files
------------

// File: rtl/operand_hazard_ctrl.sv
// ID-stage operand controller: forwards EX/MEM/WB results onto the register
// operands, interlocks on load-use hazards and freezes operands under downstream stalls.
module operand_hazard_ctrl #(
    parameter int MAX_STALL = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_read_en_1,
    input  logic                 id_read_en_2,
    input  logic [4:0]           id_read_addr_1,
    input  logic [4:0]           id_read_addr_2,
    input  logic [31:0]          rf_data_1,
    input  logic [31:0]          rf_data_2,
    input  logic                 ex_write_en,
    input  logic [4:0]           ex_write_addr,
    input  logic [31:0]          ex_result,
    input  logic                 ex_is_load,
    input  logic                 mem_write_en,
    input  logic [4:0]           mem_write_addr,
    input  logic [31:0]          mem_result,
    input  logic                 mem_is_load,
    input  logic                 mem_load_ready,
    input  logic                 wb_write_en,
    input  logic [4:0]           wb_write_addr,
    input  logic [31:0]          wb_result,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic [31:0]          reg_data_1,
    output logic [31:0]          reg_data_2,
    output logic                 stall_req,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic                 stall_timeout
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_INTERLOCK = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;

    localparam logic [8:0]           MAX_STALL_W = 9'(MAX_STALL);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

    logic [1:0]           r_state;
    logic [31:0]          r_latch1;
    logic [31:0]          r_latch2;
    logic [7:0]           r_runCount;
    logic [CNT_WIDTH-1:0] r_stallCycles;
    logic                 r_timeout;

    logic        w_use1, w_use2;
    logic        w_exHit1, w_memHit1, w_wbHit1;
    logic        w_exHit2, w_memHit2, w_wbHit2;
    logic        w_haz1, w_haz2, w_hazard;
    logic [31:0] w_fwd1, w_fwd2;
    logic        w_stallReq;
    logic [1:0]  w_nextState;
    logic        w_latchEn;

    // Register zero and unused operands never match a producer, so they read 0 and never stall.
    assign w_use1    = id_read_en_1 && (id_read_addr_1 != 5'd0);
    assign w_use2    = id_read_en_2 && (id_read_addr_2 != 5'd0);
    assign w_exHit1  = w_use1 && ex_write_en  && (ex_write_addr  == id_read_addr_1);
    assign w_memHit1 = w_use1 && mem_write_en && (mem_write_addr == id_read_addr_1);
    assign w_wbHit1  = w_use1 && wb_write_en  && (wb_write_addr  == id_read_addr_1);
    assign w_exHit2  = w_use2 && ex_write_en  && (ex_write_addr  == id_read_addr_2);
    assign w_memHit2 = w_use2 && mem_write_en && (mem_write_addr == id_read_addr_2);
    assign w_wbHit2  = w_use2 && wb_write_en  && (wb_write_addr  == id_read_addr_2);

    // A younger EX producer shadows MEM, so a ready MEM load behind an EX load still stalls.
    assign w_haz1 = (w_exHit1 && ex_is_load) ||
                    (!w_exHit1 && w_memHit1 && mem_is_load && !mem_load_ready);
    assign w_haz2 = (w_exHit2 && ex_is_load) ||
                    (!w_exHit2 && w_memHit2 && mem_is_load && !mem_load_ready);
    assign w_hazard = w_haz1 || w_haz2;

    assign w_stallReq = !rst && id_valid && !flush && w_hazard && (r_state != S_HOLD);

    always_comb begin
        w_fwd1 = 32'd0;
        if (w_use1) begin
            if (w_exHit1)       w_fwd1 = ex_result;
            else if (w_memHit1) w_fwd1 = mem_result;
            else if (w_wbHit1)  w_fwd1 = wb_result;
            else                w_fwd1 = rf_data_1;
        end
    end

    always_comb begin
        w_fwd2 = 32'd0;
        if (w_use2) begin
            if (w_exHit2)       w_fwd2 = ex_result;
            else if (w_memHit2) w_fwd2 = mem_result;
            else if (w_wbHit2)  w_fwd2 = wb_result;
            else                w_fwd2 = rf_data_2;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_latchEn   = 1'b0;
        if (flush) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_stallReq) begin
                        w_nextState = S_INTERLOCK;
                    end else if (id_valid && !w_hazard && stall_in) begin
                        w_nextState = S_HOLD;
                        w_latchEn   = 1'b1;
                    end
                end
                S_INTERLOCK: begin
                    if (!w_stallReq) begin
                        if (stall_in) begin
                            w_nextState = S_HOLD;
                            w_latchEn   = 1'b1;
                        end else begin
                            w_nextState = S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_in) w_nextState = S_IDLE;
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_latch1      <= 32'd0;
            r_latch2      <= 32'd0;
            r_runCount    <= 8'd0;
            r_stallCycles <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_latchEn) begin
                r_latch1 <= w_fwd1;
                r_latch2 <= w_fwd2;
            end
            // Run length clears on any non-stall cycle (flush included) and pins at 255.
            if (w_stallReq) begin
                if (r_runCount != 8'hFF) r_runCount <= r_runCount + 8'd1;
                if (({1'b0, r_runCount} + 9'd1) >= MAX_STALL_W) r_timeout <= 1'b1;
                if (r_stallCycles != CNT_MAX) r_stallCycles <= r_stallCycles + CNT_WIDTH'(1);
            end else begin
                r_runCount <= 8'd0;
            end
        end
    end

    assign reg_data_1    = (r_state == S_HOLD) ? r_latch1 : w_fwd1;
    assign reg_data_2    = (r_state == S_HOLD) ? r_latch2 : w_fwd2;
    assign stall_req     = w_stallReq;
    assign stall_cycles  = r_stallCycles;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Directed testbench for operand_hazard_ctrl: forwarding priority, load-use
// interlocks, operand hold under downstream stall, flush/reset and counters.
module tb_operand_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_read_en_1, id_read_en_2;
    logic [4:0]  id_read_addr_1, id_read_addr_2;
    logic [31:0] rf_data_1, rf_data_2;
    logic        ex_write_en;
    logic [4:0]  ex_write_addr;
    logic [31:0] ex_result;
    logic        ex_is_load;
    logic        mem_write_en;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_result;
    logic        mem_is_load;
    logic        mem_load_ready;
    logic        wb_write_en;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_result;
    logic        stall_in;
    logic        flush;
    logic [31:0] reg_data_1, reg_data_2;
    logic        stall_req;
    logic [3:0]  stall_cycles;
    logic        stall_timeout;

    int checkCount = 0;
    int errorCount = 0;

    // Narrow counter and timeout threshold so saturation and timeout are reachable quickly.
    operand_hazard_ctrl #(.MAX_STALL(3), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_read_en_1(id_read_en_1), .id_read_en_2(id_read_en_2),
        .id_read_addr_1(id_read_addr_1), .id_read_addr_2(id_read_addr_2),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .ex_write_en(ex_write_en), .ex_write_addr(ex_write_addr),
        .ex_result(ex_result), .ex_is_load(ex_is_load),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
        .mem_result(mem_result), .mem_is_load(mem_is_load), .mem_load_ready(mem_load_ready),
        .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr), .wb_result(wb_result),
        .stall_in(stall_in), .flush(flush),
        .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .stall_req(stall_req),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        id_valid = 0; id_read_en_1 = 0; id_read_en_2 = 0;
        id_read_addr_1 = 0; id_read_addr_2 = 0; rf_data_1 = 0; rf_data_2 = 0;
        ex_write_en = 0; ex_write_addr = 0; ex_result = 0; ex_is_load = 0;
        mem_write_en = 0; mem_write_addr = 0; mem_result = 0; mem_is_load = 0; mem_load_ready = 0;
        wb_write_en = 0; wb_write_addr = 0; wb_result = 0;
        stall_in = 0; flush = 0;
    endtask

    // Inputs are driven just after a rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        advance();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 7;
        ex_write_en = 1; ex_write_addr = 7; ex_is_load = 1;
        applyStimulus();
        checkOutput("rst_stall_req", 32'(stall_req), 32'd0);
        checkOutput("rst_cycles", 32'(stall_cycles), 32'd0);
        checkOutput("rst_timeout", 32'(stall_timeout), 32'd0);
        advance();
        clearInputs(); rst = 0;

        // Forwarding priority EX > MEM > WB > regfile
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 5; rf_data_1 = 32'h99;
        id_read_en_2 = 1; id_read_addr_2 = 6; rf_data_2 = 32'h66;
        ex_write_en = 1; ex_write_addr = 5; ex_result = 32'h11;
        mem_write_en = 1; mem_write_addr = 5; mem_result = 32'h22;
        wb_write_en = 1; wb_write_addr = 5; wb_result = 32'h33;
        applyStimulus();
        checkOutput("fwd_ex", reg_data_1, 32'h11);
        checkOutput("fwd_rf2", reg_data_2, 32'h66);
        checkOutput("fwd_no_stall", 32'(stall_req), 32'd0);
        advance(); ex_write_en = 0;
        applyStimulus();
        checkOutput("fwd_mem", reg_data_1, 32'h22);
        advance(); mem_write_en = 0;
        applyStimulus();
        checkOutput("fwd_wb", reg_data_1, 32'h33);
        advance(); wb_write_en = 0;
        applyStimulus();
        checkOutput("fwd_rf1", reg_data_1, 32'h99);
        checkOutput("fwd_cycles", 32'(stall_cycles), 32'd0);

        // Load-use: one interlock cycle, then load data forwarded from MEM
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 7;
        ex_write_en = 1; ex_write_addr = 7; ex_is_load = 1; ex_result = 32'h1234;
        applyStimulus();
        checkOutput("ldu_stall", 32'(stall_req), 32'd1);
        advance();
        ex_write_en = 0; ex_is_load = 0;
        mem_write_en = 1; mem_write_addr = 7; mem_is_load = 1; mem_load_ready = 1;
        mem_result = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("ldu_release", 32'(stall_req), 32'd0);
        checkOutput("ldu_data", reg_data_1, 32'hDEADBEEF);
        checkOutput("ldu_cycles", 32'(stall_cycles), 32'd1);

        // Slow memory: 4 stall cycles, timeout after the 3rd
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 3;
        mem_write_en = 1; mem_write_addr = 3; mem_is_load = 1; mem_result = 32'hBAD;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("slow_stall_%0d", i), 32'(stall_req), 32'd1);
            if (i == 3) checkOutput("slow_timeout_early", 32'(stall_timeout), 32'd0);
            if (i == 4) checkOutput("slow_timeout_set", 32'(stall_timeout), 32'd1);
            advance();
        end
        mem_load_ready = 1; mem_result = 32'hC0FFEE;
        applyStimulus();
        checkOutput("slow_release", 32'(stall_req), 32'd0);
        checkOutput("slow_data", reg_data_1, 32'hC0FFEE);
        checkOutput("slow_cycles", 32'(stall_cycles), 32'd5);
        advance(); clearInputs();
        applyStimulus();
        checkOutput("slow_timeout_sticky", 32'(stall_timeout), 32'd1);

        // Both operands waiting on different loads
        advance();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 8; id_read_en_2 = 1; id_read_addr_2 = 9;
        ex_write_en = 1; ex_write_addr = 8; ex_is_load = 1;
        mem_write_en = 1; mem_write_addr = 9; mem_is_load = 1;
        applyStimulus();
        checkOutput("dual_stall_both", 32'(stall_req), 32'd1);
        advance(); ex_write_en = 0; ex_is_load = 0; rf_data_1 = 32'h8888;
        applyStimulus();
        checkOutput("dual_stall_op2", 32'(stall_req), 32'd1);
        advance(); mem_load_ready = 1; mem_result = 32'h9999;
        applyStimulus();
        checkOutput("dual_release", 32'(stall_req), 32'd0);
        checkOutput("dual_data1", reg_data_1, 32'h8888);
        checkOutput("dual_data2", reg_data_2, 32'h9999);
        checkOutput("dual_cycles", 32'(stall_cycles), 32'd7);

        // Hold: operands frozen while stall_in, ignoring new WB/EX writes
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 1; rf_data_1 = 32'hA; stall_in = 1;
        applyStimulus();
        checkOutput("hold_c1", reg_data_1, 32'hA);
        advance(); wb_write_en = 1; wb_write_addr = 1; wb_result = 32'hB;
        applyStimulus();
        checkOutput("hold_c2", reg_data_1, 32'hA);
        advance(); wb_write_en = 0; rf_data_1 = 32'hB;
        ex_write_en = 1; ex_write_addr = 1; ex_is_load = 1; ex_result = 32'h77;
        applyStimulus();
        checkOutput("hold_c3", reg_data_1, 32'hA);
        checkOutput("hold_no_stall", 32'(stall_req), 32'd0);
        advance(); ex_write_en = 0; ex_is_load = 0; stall_in = 0;
        applyStimulus();
        checkOutput("hold_exit_cycle", reg_data_1, 32'hA);
        advance();
        applyStimulus();
        checkOutput("hold_after", reg_data_1, 32'hB);

        // Register zero is hard-wired; disabled operand reads 0
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 0;
        id_read_en_2 = 0; id_read_addr_2 = 5; rf_data_2 = 32'h5A5A;
        ex_write_en = 1; ex_write_addr = 0; ex_is_load = 1; ex_result = 32'h55;
        applyStimulus();
        checkOutput("r0_data", reg_data_1, 32'd0);
        checkOutput("r0_stall", 32'(stall_req), 32'd0);
        checkOutput("unused_op2", reg_data_2, 32'd0);

        // Flush during INTERLOCK beats hazard and stall_in
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 7;
        ex_write_en = 1; ex_write_addr = 7; ex_is_load = 1; ex_result = 32'h7777;
        applyStimulus();
        checkOutput("flush_pre_stall", 32'(stall_req), 32'd1);
        advance(); flush = 1; stall_in = 1;
        applyStimulus();
        checkOutput("flush_stall", 32'(stall_req), 32'd0);
        checkOutput("flush_cycles", 32'(stall_cycles), 32'd8);
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 2; rf_data_1 = 32'h2222;
        applyStimulus();
        checkOutput("flush_idle", reg_data_1, 32'h2222);

        // INTERLOCK resolving while stall_in goes straight to HOLD
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 4;
        ex_write_en = 1; ex_write_addr = 4; ex_is_load = 1;
        applyStimulus();
        checkOutput("ilk_stall", 32'(stall_req), 32'd1);
        advance(); ex_write_en = 0; ex_is_load = 0; rf_data_1 = 32'h4444; stall_in = 1;
        applyStimulus();
        checkOutput("ilk_resolve", reg_data_1, 32'h4444);
        advance(); rf_data_1 = 32'h5555;
        applyStimulus();
        checkOutput("ilk_hold", reg_data_1, 32'h4444);
        checkOutput("ilk_cycles", 32'(stall_cycles), 32'd9);
        advance(); stall_in = 0;
        applyStimulus();
        checkOutput("ilk_hold_exit", reg_data_1, 32'h4444);

        // Long interlock: stall_cycles saturates at 15
        advance(); clearInputs();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 6;
        ex_write_en = 1; ex_write_addr = 6; ex_is_load = 1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus();
            checkOutput($sformatf("sat_stall_%0d", i), 32'(stall_req), 32'd1);
            if (i == 10) checkOutput("sat_cycles", 32'(stall_cycles), 32'd15);
            advance();
        end
        clearInputs();
        applyStimulus();
        checkOutput("sat_cycles_after", 32'(stall_cycles), 32'd15);

        // Reset while in HOLD aborts to IDLE and clears counters
        advance();
        id_valid = 1; id_read_en_1 = 1; id_read_addr_1 = 1; rf_data_1 = 32'hAB; stall_in = 1;
        applyStimulus();
        advance(); rf_data_1 = 32'hCD; rst = 1;
        applyStimulus();
        checkOutput("rsthold_latched", reg_data_1, 32'hAB);
        checkOutput("rsthold_timeout_pre", 32'(stall_timeout), 32'd1);
        advance();
        applyStimulus();
        checkOutput("rsthold_idle", reg_data_1, 32'hCD);
        checkOutput("rsthold_cycles", 32'(stall_cycles), 32'd0);
        checkOutput("rsthold_timeout", 32'(stall_timeout), 32'd0);
        checkOutput("rsthold_stall", 32'(stall_req), 32'd0);
        advance(); rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
